// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU ops, mux selects and step encoding for the CPU control unit
package cpu_ctrl_pkg;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_BR   = 6'h06;
  localparam logic [5:0] OP_BEQ  = 6'h26;
  localparam logic [5:0] OP_STW  = 6'h15;
  localparam logic [5:0] OP_LDW  = 6'h17;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic B_RB    = 1'b0;
  localparam logic B_IMM   = 1'b1;
  localparam logic INC_4   = 1'b0;
  localparam logic INC_IMM = 1'b1;
  localparam logic MA_RZ   = 1'b0;
  localparam logic MA_PC   = 1'b1;
  localparam logic PC_RA   = 1'b0;
  localparam logic PC_ADD  = 1'b1;
  localparam logic [1:0] C_SRC2 = 2'd0;
  localparam logic [1:0] C_DEST = 2'd1;
  localparam logic [1:0] C_R31  = 2'd2;
  localparam logic [1:0] Y_RZ   = 2'd0;
  localparam logic [1:0] Y_MEM  = 2'd1;
  localparam logic [1:0] Y_PCT  = 2'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_HALT} state_t;
endpackage

// File: rtl/cpu_control_unit_op_decode.sv
// cpu_op_decode: combinational opcode classifier
module cpu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_addi,
  output logic       is_br,
  output logic       is_beq,
  output logic       is_ldw,
  output logic       is_stw,
  output logic       illegal
);
  assign is_addi = opcode == OP_ADDI;
  assign is_br   = opcode == OP_BR;
  assign is_beq  = opcode == OP_BEQ;
  assign is_ldw  = opcode == OP_LDW;
  assign is_stw  = opcode == OP_STW;
  assign illegal = !(is_addi || is_br || is_beq || is_ldw || is_stw);
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: five-step multi-cycle sequencer with memory handshake and watchdog
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       iClk,
  input  logic       nRst,
  input  logic [5:0] iOpcode,
  input  logic       iAluZero,
  input  logic       iMemReady,
  output logic [4:0] oStep,
  output logic       oPcEn,
  output logic       oPcTempEn,
  output logic       oIrEn,
  output logic       oRfWrite,
  output logic       oMemEn,
  output logic       oMemRW,
  output logic       oBSel,
  output logic       oIncSel,
  output logic       oMaSel,
  output logic       oPcSel,
  output logic [1:0] oCSel,
  output logic [1:0] oYSel,
  output logic [3:0] oAluOp,
  output logic       oIllegal,
  output logic       oFault
);
  state_t state, nxt;
  logic [31:0] cnt;
  logic is_addi, is_br, is_beq, is_ldw, is_stw, illegal;
  logic mem_req, wait_c, tmo, take;
  cpu_op_decode u_dec (
    .opcode (iOpcode),
    .is_addi(is_addi),
    .is_br  (is_br),
    .is_beq (is_beq),
    .is_ldw (is_ldw),
    .is_stw (is_stw),
    .illegal(illegal)
  );
  assign mem_req = (state == ST_S1) || (state == ST_S4 && (is_ldw || is_stw));
  assign wait_c  = mem_req && !iMemReady;
  assign tmo     = (MEM_TIMEOUT != 0) && wait_c && (cnt == 32'(MEM_TIMEOUT - 1));
  assign take    = is_br || (is_beq && iAluZero);
  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      oIllegal <= 1'b0;
      oFault   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= wait_c ? cnt + 32'd1 : '0;
      if (tmo) oFault <= 1'b1;
      if (state == ST_S2 && illegal) oIllegal <= 1'b1;
    end
  always_comb begin
    nxt       = state;
    oStep     = '0;
    oPcEn     = 1'b0;
    oPcTempEn = 1'b0;
    oIrEn     = 1'b0;
    oRfWrite  = 1'b0;
    oMemEn    = mem_req;
    oMemRW    = 1'b0;
    oBSel     = B_RB;
    oIncSel   = INC_4;
    oMaSel    = MA_RZ;
    oPcSel    = PC_RA;
    oCSel     = C_SRC2;
    oYSel     = Y_RZ;
    oAluOp    = ALU_ADD;
    case (state)
      ST_IDLE: nxt = ST_S1;
      ST_S1: begin
        oStep     = 5'b00001;
        oMaSel    = MA_PC;
        oIrEn     = iMemReady;
        oPcTempEn = iMemReady;
        oPcEn     = iMemReady;
        oPcSel    = iMemReady ? PC_ADD : PC_RA;
        nxt       = iMemReady ? ST_S2 : tmo ? ST_HALT : ST_S1;
      end
      ST_S2: begin
        oStep = 5'b00010;
        nxt   = illegal ? ST_HALT : ST_S3;
      end
      ST_S3: begin
        oStep   = 5'b00100;
        oBSel   = (is_addi || is_ldw || is_stw) ? B_IMM : B_RB;
        oAluOp  = is_beq ? ALU_SUB : ALU_ADD;
        oPcEn   = take;
        oPcSel  = take ? PC_ADD : PC_RA;
        oIncSel = take ? INC_IMM : INC_4;
        nxt     = ST_S4;
      end
      ST_S4: begin
        oStep  = 5'b01000;
        oMemRW = is_stw;
        oYSel  = is_ldw ? Y_MEM : Y_RZ;
        nxt    = (!mem_req || iMemReady) ? ST_S5 : tmo ? ST_HALT : ST_S4;
      end
      ST_S5: begin
        oStep    = 5'b10000;
        oRfWrite = is_addi || is_ldw;
        nxt      = ST_S1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed vector table, corner sequences and random instruction traces
module tb_cpu_control_unit;
  import cpu_ctrl_pkg::*;
  logic iClk = 1'b0, nRst = 1'b0;
  logic [5:0] opcode = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic [4:0] step;
  logic pc_en, pct_en, ir_en, rf_wr, mem_en, mem_rw, b_sel, inc_sel, ma_sel, pc_sel;
  logic [1:0] c_sel, y_sel;
  logic [3:0] alu_op;
  logic ill, fault;
  logic [22:0] act;
  int checks = 0, errors = 0;
  cpu_control_unit #(.MEM_TIMEOUT(4)) dut (
    .iClk(iClk), .nRst(nRst), .iOpcode(opcode), .iAluZero(alu_zero), .iMemReady(mem_ready),
    .oStep(step), .oPcEn(pc_en), .oPcTempEn(pct_en), .oIrEn(ir_en), .oRfWrite(rf_wr),
    .oMemEn(mem_en), .oMemRW(mem_rw), .oBSel(b_sel), .oIncSel(inc_sel), .oMaSel(ma_sel),
    .oPcSel(pc_sel), .oCSel(c_sel), .oYSel(y_sel), .oAluOp(alu_op), .oIllegal(ill), .oFault(fault)
  );
  always #5 iClk = ~iClk;
  assign act = {step, pc_en, pct_en, ir_en, rf_wr, mem_en, mem_rw, b_sel, inc_sel, ma_sel, pc_sel,
                c_sel, y_sel, alu_op};
  // enable bit order: pc_en pct_en ir_en rf_wr mem_en mem_rw b_sel inc_sel ma_sel pc_sel
  localparam logic [9:0] E_NONE  = 10'b0000000000;
  localparam logic [9:0] E_FETCH = 10'b1110100011;
  localparam logic [9:0] E_FWAIT = 10'b0000100010;
  localparam logic [9:0] E_IMM   = 10'b0000001000;
  localparam logic [9:0] E_BRT   = 10'b1000000101;
  localparam logic [9:0] E_LD    = 10'b0000100000;
  localparam logic [9:0] E_ST    = 10'b0000110000;
  localparam logic [9:0] E_WB    = 10'b0001000000;
  localparam logic [4:0] S1 = 5'b00001, S2 = 5'b00010, S3 = 5'b00100, S4 = 5'b01000, S5 = 5'b10000;
  typedef struct {
    logic [5:0]  op;
    logic        r;
    logic        z;
    logic [22:0] e;
    string       nm;
  } vec_t;
  vec_t tbl[$];
  vec_t trace[$];
  function automatic logic [22:0] mk(input logic [4:0] s, input logic [9:0] en,
                                     input logic [1:0] y = 2'd0, input logic [3:0] a = 4'd0);
    return {s, en, 2'b00, y, a};
  endfunction
  function automatic vec_t mv(input logic [5:0] op, input logic r, input logic z,
                              input logic [22:0] e, input string nm);
    vec_t v;
    v = '{op, r, z, e, nm};
    return v;
  endfunction
  task automatic chk(input string nm, input logic [22:0] a, input logic [22:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic sticky(input string nm, input logic [1:0] e);
    chk(nm, {21'b0, ill, fault}, {21'b0, e});
  endtask
  task automatic cyc(input vec_t v);
    @(negedge iClk);
    opcode = v.op;
    mem_ready = v.r;
    alu_zero = v.z;
    #1 chk(v.nm, act, v.e);
  endtask
  task automatic reset_dut();
    @(negedge iClk);
    nRst = 1'b0;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    #1 chk("rst_out", act, '0);
    sticky("rst_sticky", 2'b00);
    @(negedge iClk);
    nRst = 1'b1;
    #1 chk("idle", act, '0);
  endtask
  // instruction-level trace builder: fetch waits, decode, execute, memory waits, writeback
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    logic z;
    logic mem;
    mem = (op == OP_LDW) || (op == OP_STW);
    for (int i = 0; i < fw; i++)
      trace.push_back(mv(op, 1'b0, 1'($urandom_range(0, 1)), mk(S1, E_FWAIT), "rnd_fwait"));
    trace.push_back(mv(op, 1'b1, 1'($urandom_range(0, 1)), mk(S1, E_FETCH), "rnd_fetch"));
    trace.push_back(mv(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk(S2, E_NONE), "rnd_s2"));
    z = 1'($urandom_range(0, 1));
    if (op == OP_BEQ) trace.push_back(mv(op, 1'b0, z, mk(S3, z ? E_BRT : E_NONE, 2'd0, ALU_SUB), "rnd_s3_beq"));
    else if (op == OP_BR) trace.push_back(mv(op, 1'b0, z, mk(S3, E_BRT), "rnd_s3_br"));
    else trace.push_back(mv(op, 1'b0, z, mk(S3, E_IMM), "rnd_s3_imm"));
    if (mem) begin
      for (int i = 0; i <= mw; i++)
        trace.push_back(mv(op, 1'(i == mw), 1'($urandom_range(0, 1)),
                           op == OP_LDW ? mk(S4, E_LD, Y_MEM) : mk(S4, E_ST), "rnd_s4_mem"));
    end else trace.push_back(mv(op, 1'($urandom_range(0, 1)), 1'b0, mk(S4, E_NONE), "rnd_s4"));
    trace.push_back(mv(op, 1'($urandom_range(0, 1)), 1'b0,
                       mk(S5, (op == OP_ADDI || op == OP_LDW) ? E_WB : E_NONE), "rnd_s5"));
  endtask
  initial begin
    logic [5:0] legal [5];
    legal = '{OP_ADDI, OP_BR, OP_BEQ, OP_LDW, OP_STW};
    reset_dut();
    tbl.push_back(mv(OP_ADDI, 1, 0, mk(S1, E_FETCH), "addi_s1"));
    tbl.push_back(mv(OP_ADDI, 1, 0, mk(S2, E_NONE), "addi_s2"));
    tbl.push_back(mv(OP_ADDI, 1, 0, mk(S3, E_IMM), "addi_s3"));
    tbl.push_back(mv(OP_ADDI, 1, 0, mk(S4, E_NONE), "addi_s4"));
    tbl.push_back(mv(OP_ADDI, 1, 0, mk(S5, E_WB), "addi_s5"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S1, E_FETCH), "beqt_s1"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S2, E_NONE), "beqt_s2"));
    tbl.push_back(mv(OP_BEQ, 1, 1, mk(S3, E_BRT, 2'd0, ALU_SUB), "beqt_s3"));
    tbl.push_back(mv(OP_BEQ, 1, 1, mk(S4, E_NONE), "beqt_s4"));
    tbl.push_back(mv(OP_BEQ, 1, 1, mk(S5, E_NONE), "beqt_s5"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S1, E_FETCH), "beqn_s1"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S2, E_NONE), "beqn_s2"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S3, E_NONE, 2'd0, ALU_SUB), "beqn_s3"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S4, E_NONE), "beqn_s4"));
    tbl.push_back(mv(OP_BEQ, 1, 0, mk(S5, E_NONE), "beqn_s5"));
    tbl.push_back(mv(OP_STW, 1, 0, mk(S1, E_FETCH), "stw_s1"));
    tbl.push_back(mv(OP_STW, 1, 0, mk(S2, E_NONE), "stw_s2"));
    tbl.push_back(mv(OP_STW, 1, 0, mk(S3, E_IMM), "stw_s3"));
    tbl.push_back(mv(OP_STW, 1, 0, mk(S4, E_ST), "stw_s4"));
    tbl.push_back(mv(OP_STW, 1, 0, mk(S5, E_NONE), "stw_s5"));
    tbl.push_back(mv(OP_BR, 1, 0, mk(S1, E_FETCH), "br_s1"));
    tbl.push_back(mv(OP_BR, 1, 0, mk(S2, E_NONE), "br_s2"));
    tbl.push_back(mv(OP_BR, 1, 0, mk(S3, E_BRT), "br_s3"));
    tbl.push_back(mv(OP_BR, 1, 0, mk(S4, E_NONE), "br_s4"));
    tbl.push_back(mv(OP_BR, 1, 0, mk(S5, E_NONE), "br_s5"));
    foreach (tbl[i]) cyc(tbl[i]);
    // LDW with three stalled memory cycles: eight cycles until the next fetch
    cyc(mv(OP_LDW, 1, 0, mk(S1, E_FETCH), "ldw_s1"));
    cyc(mv(OP_LDW, 1, 0, mk(S2, E_NONE), "ldw_s2"));
    cyc(mv(OP_LDW, 1, 0, mk(S3, E_IMM), "ldw_s3"));
    for (int i = 0; i < 3; i++) cyc(mv(OP_LDW, 0, 0, mk(S4, E_LD, Y_MEM), "ldw_s4_wait"));
    cyc(mv(OP_LDW, 1, 0, mk(S4, E_LD, Y_MEM), "ldw_s4_ready"));
    cyc(mv(OP_LDW, 1, 0, mk(S5, E_WB), "ldw_s5"));
    cyc(mv(OP_ADDI, 0, 0, mk(S1, E_FWAIT), "ldw_next_s1"));
    // illegal opcode halts until reset
    reset_dut();
    cyc(mv(6'h3F, 1, 0, mk(S1, E_FETCH), "ill_s1"));
    cyc(mv(6'h3F, 1, 0, mk(S2, E_NONE), "ill_s2"));
    sticky("ill_pre", 2'b00);
    for (int i = 0; i < 3; i++) cyc(mv(6'h3F, 1'(i[0]), 0, mk(5'd0, E_NONE), "ill_halt"));
    sticky("ill_sticky", 2'b10);
    // fetch stalls past the watchdog limit
    reset_dut();
    for (int i = 0; i < 4; i++) cyc(mv(OP_ADDI, 0, 0, mk(S1, E_FWAIT), "to_wait"));
    cyc(mv(OP_ADDI, 0, 0, mk(5'd0, E_NONE), "to_halt"));
    sticky("to_fault", 2'b01);
    cyc(mv(OP_ADDI, 1, 0, mk(5'd0, E_NONE), "to_stay"));
    // ready on the final allowed cycle wins over the watchdog
    reset_dut();
    for (int i = 0; i < 3; i++) cyc(mv(OP_ADDI, 0, 0, mk(S1, E_FWAIT), "rw_wait"));
    cyc(mv(OP_ADDI, 1, 0, mk(S1, E_FETCH), "rw_ready"));
    cyc(mv(OP_ADDI, 1, 0, mk(S2, E_NONE), "rw_s2"));
    sticky("rw_nofault", 2'b00);
    cyc(mv(OP_LDW, 1, 0, mk(S3, E_IMM), "mr_s3"));
    cyc(mv(OP_LDW, 0, 0, mk(S4, E_LD, Y_MEM), "mr_s4"));
    #2 nRst = 1'b0;
    #1 chk("mr_async", act, '0);
    // random instruction stream against the trace model
    reset_dut();
    for (int n = 0; n < 40; n++)
      add_instr(legal[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3));
    foreach (trace[i]) cyc(trace[i]);
    sticky("rnd_sticky", 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle control sequencer for the 32-bit five-step CPU datapath (PC, PC_Temp, IR, RA/RB/RM/RY/RZ, register file, ALU, B/C/INC/MA/PC/Y muxes).
- Owns the step state machine and decodes the IR opcode.
- Drives every datapath enable, mux select, ALU op and the memory request.
- Stalls on a ready-based memory handshake, with a watchdog timeout.

Parameters:
- MEM_TIMEOUT, 16: cycles a memory request may wait for iMemReady before a fault; 0 disables the watchdog.

Ports:
- iClk  in  1  clock
- nRst  in  1  reset
- iOpcode  in  6  IR[5:0] from IR_out
- iAluZero  in  1  ALU zero flag, combinational in the current cycle
- iMemReady  in  1  memory completes the request this cycle
- oStep  out  5  one-hot step S1..S5; 0 in IDLE/HALT
- oPcEn, oPcTempEn, oIrEn, oRfWrite  out  1 each  register enables
- oMemEn  out  1  memory request
- oMemRW  out  1  1=write, 0=read
- oBSel  out  1  0=RB, 1=imm32
- oIncSel  out  1  0=+4, 1=imm32 offset
- oMaSel  out  1  0=RZ, 1=PC
- oPcSel  out  1  0=RA, 1=PC adder
- oCSel  out  2  0=IR_src2, 1=IR_dest, 2=r31
- oYSel  out  2  0=RZ, 1=iMemData, 2=PC_Temp
- oAluOp  out  4  ALU operation
- oIllegal  out  1  sticky: illegal opcode
- oFault  out  1  sticky: memory timeout

Behaviour:
- States: IDLE, S1..S5, HALT.
- Async reset (nRst low) -> IDLE; clears oIllegal, oFault and the wait counter.
- Outputs are combinational from state and inputs. In IDLE and HALT all enables, oMemEn and oStep are 0 and selects are 0.
- IDLE -> S1 on the first iClk edge after reset is released.
- S1 (fetch):
  - oMaSel=1, oMemEn=1, oMemRW=0.
  - Hold S1 while !iMemReady.
  - In the iMemReady cycle: oIrEn=1, oPcTempEn=1, oPcEn=1, oPcSel=1, oIncSel=0; next state S2.
- S2 (decode/operand read): RA/RB load unconditionally; no enables asserted.
  - Opcode not in {ADDI, BR, BEQ, LDW, STW} -> HALT with oIllegal=1.
  - Otherwise -> S3.
- S3 (execute):
  - ADDI/LDW/STW: oBSel=1, oAluOp=ADD.
  - BEQ: oBSel=0, oAluOp=SUB. If iAluZero: oPcEn=1, oPcSel=1, oIncSel=1.
  - BR: oPcEn=1, oPcSel=1, oIncSel=1.
- S4 (memory):
  - LDW: oMaSel=0, oMemEn=1, oMemRW=0, oYSel=1; hold S4 until iMemReady.
  - STW: oMaSel=0, oMemEn=1, oMemRW=1; hold S4 until iMemReady.
  - ADDI: oYSel=0. BR/BEQ: no action.
- S5 (writeback): ADDI/LDW: oRfWrite=1, oCSel=0. Others: none. Next state S1.
- Every instruction passes through all five steps; latency is 5 cycles plus memory wait cycles.
- Memory watchdog:
  - The counter resets on entering S1 or S4 and increments each waiting cycle (oMemEn=1 && !iMemReady).
  - When the count reaches MEM_TIMEOUT (if MEM_TIMEOUT != 0): -> HALT, oFault=1, oMemEn drops the next cycle.
  - iMemReady in the same cycle the count reaches MEM_TIMEOUT: ready wins and no fault is raised.
- oMemEn stays asserted with stable oMemRW and oMaSel for the whole wait.
- HALT is exited only by reset. Reset mid-wait drops oMemEn asynchronously.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants OP_ADDI=6'h04, OP_BR=6'h06, OP_BEQ=6'h26, OP_STW=6'h15, OP_LDW=6'h17;
  - ALU_ADD=4'd0, ALU_SUB=4'd1;
  - state encoding;
  - mux select constants for B/C/INC/MA/PC/Y.
- Sub-module cpu_op_decode: combinational opcode -> {is_addi, is_br, is_beq, is_ldw, is_stw, illegal}.
- FSM, watchdog and output logic stay in cpu_control_unit.

Test Plan:
- Reset release, iMemReady=1 every cycle, ADDI (6'h04) -> IDLE 1 cycle, then oStep 00001,00010,00100,01000,10000; oRfWrite=1 only in S5 with oCSel=0, oYSel=0; back to S1.
- LDW (6'h17), iMemReady low 3 cycles in S4 -> S4 held 4 cycles with oMemEn=1, oMemRW=0, oMaSel=0, oYSel=1; oRfWrite=1 in S5; total 8 cycles.
- STW (6'h15) -> S4 oMemEn=1, oMemRW=1; oRfWrite never asserted.
- BEQ (6'h26), iAluZero=1 in S3 -> oPcEn=1, oIncSel=1, oAluOp=1 in S3. Repeat with iAluZero=0 -> oPcEn=0 in S3.
- Opcode 6'h3F -> HALT after S2, oIllegal=1, oStep=0, no further oMemEn until reset; a reset pulse clears oIllegal.
- MEM_TIMEOUT=4, iMemReady held 0 in S1 -> oFault=1 and HALT after 4 wait cycles. Ready arriving on the 4th wait cycle -> no fault, proceeds to S2.
